// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath widths and instruction encodings
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_entry_array.sv
// fetch_entry_array: fetch buffer storage with allocate, fill and head-read ports
module fetch_entry_array #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              alloc_en,
    input  logic [PTR_W-1:0]  alloc_idx,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill_en,
    input  logic [PTR_W-1:0]  fill_idx,
    input  logic [INST_W-1:0] fill_data,
    input  logic              pop_en,
    input  logic [PTR_W-1:0]  head_idx,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_data,
    output logic              head_filled
);
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [INST_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;

    assign head_pc = pc_q[head_idx];
    assign head_data = data_q[head_idx];
    assign head_filled = filled_q[head_idx];

    // Per-entry update; clr only invalidates, rst also zeroes the payload
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                pc_q[i] <= '0;
                data_q[i] <= '0;
                filled_q[i] <= 1'b0;
            end else begin
                if (alloc_en && alloc_idx == PTR_W'(i)) pc_q[i] <= alloc_pc;
                if (fill_en && fill_idx == PTR_W'(i)) data_q[i] <= fill_data;
                if (clr) filled_q[i] <= 1'b0;
                else if (alloc_en && alloc_idx == PTR_W'(i)) filled_q[i] <= 1'b0;
                else if (fill_en && fill_idx == PTR_W'(i)) filled_q[i] <= 1'b1;
                else if (pop_en && head_idx == PTR_W'(i)) filled_q[i] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: issues PC fetches to imem and queues in-order responses for decode
module inst_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [INST_W-1:0] inst_data,
    input  logic              inst_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [PTR_W:0]   head, fill, tail, unfilled;
    logic [CNT_W-1:0] alloc_cnt, drop_cnt;
    logic             credit, pop, rsp_drop, rsp_fill, rsp_expected;

    // Dropped responses still hold credit so a refetch can never outrun them
    assign credit = {1'b0, alloc_cnt} + {1'b0, drop_cnt} < SUM_W'(DEPTH);
    assign imem_req_valid = pc_valid & credit & ~flush & ~rst;
    assign imem_req_addr = pc_addr;
    assign pc_ready = imem_req_valid & imem_req_ready;
    assign pop = inst_valid & inst_ready & ~flush;
    assign unfilled = tail - fill;
    assign rsp_expected = (drop_cnt != '0) || (unfilled != '0);
    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & (unfilled != '0) & ~flush;

    fetch_entry_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) entries (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .alloc_en(pc_ready),
        .alloc_idx(tail[PTR_W-1:0]),
        .alloc_pc(pc_addr),
        .fill_en(rsp_fill),
        .fill_idx(fill[PTR_W-1:0]),
        .fill_data(imem_rsp_data),
        .pop_en(pop),
        .head_idx(head[PTR_W-1:0]),
        .head_pc(inst_pc),
        .head_data(inst_data),
        .head_filled(inst_valid)
    );

    // Pointers and counters; a flush turns every pending response into a drop
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            fill <= '0;
            tail <= '0;
            alloc_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            head <= tail;
            fill <= tail;
            alloc_cnt <= '0;
            drop_cnt <= drop_cnt + unfilled - CNT_W'(imem_rsp_valid & rsp_expected);
        end else begin
            tail <= tail + CNT_W'(pc_ready);
            fill <= fill + CNT_W'(rsp_fill);
            head <= head + CNT_W'(pop);
            alloc_cnt <= alloc_cnt + CNT_W'(pc_ready) - CNT_W'(pop);
            drop_cnt <= drop_cnt - CNT_W'(rsp_drop);
        end
    end

    // Memory must never answer a request that was not made
    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid) assert (rsp_expected);
    end
endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Consumer end of the PC interface: accepts fetch addresses from the program counter and issues them to instruction memory over a valid/ready request channel.
- Collects in-order memory responses into a DEPTH-entry buffer and presents {pc, instruction} pairs to decode over valid/ready.
- On a branch redirect (flush), discards buffered entries and drops all in-flight responses.
- Sits between the PC stage and the decode stage.

Parameters:
- DEPTH, 4: buffer entries, i.e. the maximum number of issued-but-not-consumed fetches; power of two, at least 2.
- ADDR_W, 32: PC / fetch address width.
- INST_W, 32: instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_valid  in  1  fetch address presented.
- pc_addr  in  ADDR_W  fetch address.
- pc_ready  out  1  address accepted this cycle (comb).
- flush  in  1  branch redirect; discard everything older.
- imem_req_valid  out  1  request to instruction memory (comb).
- imem_req_addr  out  ADDR_W  equals pc_addr.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response strobe; in order, one per accepted request, never before the cycle after acceptance; no backpressure.
- imem_rsp_data  in  INST_W  instruction word.
- inst_valid  out  1  head entry filled (registered state).
- inst_pc  out  ADDR_W  PC of head entry.
- inst_data  out  INST_W  instruction of head entry.
- inst_ready  in  1  decode consumes head.

Behaviour:
- State: entry array {pc, data, filled}; head, fill, and tail pointers (PTR_W+1 bits, wrap modulo DEPTH); alloc_cnt in 0..DEPTH; drop_cnt in 0..DEPTH.
- Issue (combinational path pc -> imem):
  - credit = alloc_cnt + drop_cnt < DEPTH.
  - imem_req_valid = pc_valid & credit & !flush.
  - pc_ready = imem_req_valid & imem_req_ready.
  - On pc_ready: write pc_addr at tail, filled=0, tail++, alloc_cnt++.
- Response:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise imem_rsp_data is written at fill, filled=1, fill++.
  - A response with no outstanding request is a protocol error; it is ignored and flagged by an assertion.
- Output:
  - inst_valid = entry[head].filled; inst_pc and inst_data are taken from the head entry.
  - On inst_valid & inst_ready: clear filled, head++, alloc_cnt--.
  - Latency: a response in cycle N gives inst_valid in cycle N+1 if that entry is at head. Issue-to-decode is at least 2 cycles.
- Flush (highest priority):
  - Next cycle: all entries invalid; head=fill=tail (set to the current tail); alloc_cnt=0.
  - drop_cnt_next = drop_cnt + (unfilled allocated entries) - (imem_rsp_valid ? 1 : 0). Every pending response becomes unwanted, including one arriving in the flush cycle.
  - No issue and no pop occur in the flush cycle, even if pc_valid/inst_ready are high.
  - Issue resumes the following cycle while drop_cnt>0, since credit covers the dropped responses.
- Full: alloc_cnt + drop_cnt == DEPTH drops pc_ready to 0. A pop and an issue in the same cycle are both allowed only if credit already held at the start of the cycle; there is no same-cycle credit return.
- Empty: inst_valid=0; a response into an empty buffer is visible the next cycle, with no bypass.
- Simultaneous issue + response + pop: all three update independently; alloc_cnt changes by +issue - pop.
- Reset (synchronous, rst=1 at the edge):
  - Pointers, counters, and filled bits cleared.
  - inst_valid=0, inst_pc=0, inst_data=0.
  - pc_ready and imem_req_valid are forced 0 while rst is high.
  - Reset mid-operation discards in-flight responses implicitly; memory is reset with the same rst.

Decomposition:
- Shared package cpu_pkg: INST_W, ADDR_W, and the NOP encoding constant (32'h00000013), for decode to use on bubbles.
- One natural sub-module: fetch_entry_array. It is a DEPTH x (ADDR_W+INST_W+1) register file with allocate-write, fill-write, and head-read ports and a synchronous clear.
- Pointer, credit, and drop logic stay in inst_fetch_buffer.

Test Plan:
- Streaming: pc 0x00, 0x04, 0x08, 0x0C; memory ready with 1-cycle latency and data 0xA0..0xA3; inst_ready=1. Expect inst outputs (0x00,0xA0)…(0x0C,0xA3) in order, each 2 cycles after issue, with no gaps once streaming.
- Backpressure/full: DEPTH=4, inst_ready=0, pc_valid=1. Expect exactly 4 requests accepted, pc_ready=0 from then on. Raise inst_ready for one cycle: one pop, then pc_ready=1 the next cycle.
- Flush with in-flight: 3 requests outstanding at 4-cycle latency, flush asserted. Expect the 3 later responses discarded. New pc 0x100 is issued the cycle after flush, and its data 0xBB emerges as (0x100,0xBB) with no stale entry.
- Flush coincident with response and inst_ready: that response is dropped, drop_cnt accounts for it, no pop occurs, inst_valid=0 next cycle.
- Reset mid-stream: rst for 1 cycle with 2 entries filled. Next cycle inst_valid=0, inst_pc=0, pc_ready follows credit, and fetch of 0x00 proceeds normally.
- Variable latency 1–5 cycles, random inst_ready, random flushes, 10k cycles. A scoreboard checks in-order pc/data pairing and that there is never an overflow or a stale post-flush output.
